// File: rtl/pipe_pkg.sv
// Shared types and constants for the hazard controller: FSM states,
// forwarding select codes and the register-match helper.
package pipe_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // A producer supplies src only if it writes and its target is not $zero.
  function automatic logic writes_to(input logic we, input logic [4:0] dest,
                                     input logic [4:0] src);
    return we && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of the hazard controller: register/control snoops
// from ID, EX, MEM, WB in; stall, flush, forward and event counters out.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             ex_MemRead;
  logic             ex_RegWrite;
  logic [4:0]       ex_reg_dest;
  logic [4:0]       ex_rs;
  logic [4:0]       ex_rt;
  logic             mem_RegWrite;
  logic [4:0]       mem_reg_dest;
  logic             wb_RegWrite;
  logic [4:0]       wb_reg_dest;
  logic             branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_events;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_RegWrite, ex_reg_dest,
           ex_rs, ex_rt, mem_RegWrite, mem_reg_dest, wb_RegWrite, wb_reg_dest,
           branch_taken,
    input  pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
           ex_mem_flush, fwd_a, fwd_b, stall_events, flush_events
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_RegWrite, ex_reg_dest,
           ex_rs, ex_rt, mem_RegWrite, mem_reg_dest, wb_RegWrite, wb_reg_dest,
           branch_taken,
    output pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush,
           ex_mem_flush, fwd_a, fwd_b, stall_events, flush_events
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding select for one EX source register; the younger
// EX/MEM producer takes priority over MEM/WB.
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_we,
  input  logic [4:0] mem_dest,
  input  logic       wb_we,
  input  logic [4:0] wb_dest,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (writes_to(mem_we, mem_dest, src)) begin
      sel = FWD_MEM;
    end else if (writes_to(wb_we, wb_dest, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / RAW stall FSM, branch flush and saturating event counters.
// Define HAZARD_FORWARD_EN to enable forwarding and the load-use-only stall rule.
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic        clock,
  input  logic        reset,
  hazard_ctrl_if.slave hz
);

  state_t           state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic [1:0]       need;
  logic             ex_hit;
  logic             stall;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign ex_hit = writes_to(hz.ex_RegWrite, hz.ex_reg_dest, hz.id_rs) ||
                  (hz.id_uses_rt && writes_to(hz.ex_RegWrite, hz.ex_reg_dest, hz.id_rt));

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time: one bubble covers it.
  assign need = (hz.ex_MemRead && ex_hit) ? 2'd1 : 2'd0;

  hazard_fwd_unit u_fwd_a (
    .src     (hz.ex_rs),
    .mem_we  (hz.mem_RegWrite),
    .mem_dest(hz.mem_reg_dest),
    .wb_we   (hz.wb_RegWrite),
    .wb_dest (hz.wb_reg_dest),
    .sel     (sel_a)
  );

  hazard_fwd_unit u_fwd_b (
    .src     (hz.ex_rt),
    .mem_we  (hz.mem_RegWrite),
    .mem_dest(hz.mem_reg_dest),
    .wb_we   (hz.wb_RegWrite),
    .wb_dest (hz.wb_reg_dest),
    .sel     (sel_b)
  );
`else
  logic mem_hit;

  // Write-before-read register file means a WB producer never needs a stall.
  assign mem_hit = writes_to(hz.mem_RegWrite, hz.mem_reg_dest, hz.id_rs) ||
                   (hz.id_uses_rt && writes_to(hz.mem_RegWrite, hz.mem_reg_dest, hz.id_rt));
  assign need  = ex_hit ? 2'd2 : (mem_hit ? 2'd1 : 2'd0);
  assign sel_a = FWD_RF;
  assign sel_b = FWD_RF;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (hz.branch_taken) begin
      state_nxt = RUN;
      cnt_nxt   = 2'd0;
    end else if (state == STALL) begin
      cnt_nxt   = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
      state_nxt = (cnt <= 2'd1) ? RUN : STALL;
    end else if (need >= 2'd2) begin
      state_nxt = STALL;
      cnt_nxt   = need - 2'd1;
    end
  end

  assign stall = !hz.branch_taken && ((state == STALL) || (need != 2'd0));

  always_comb begin
    hz.pc_write     = 1'b1;
    hz.if_id_write  = 1'b1;
    hz.id_ex_bubble = 1'b0;
    hz.if_id_flush  = 1'b0;
    hz.id_ex_flush  = 1'b0;
    hz.ex_mem_flush = 1'b0;
    hz.fwd_a        = sel_a;
    hz.fwd_b        = sel_b;
    if (reset) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
      hz.fwd_a        = FWD_RF;
      hz.fwd_b        = FWD_RF;
    end else if (hz.branch_taken) begin
      hz.if_id_flush  = 1'b1;
      hz.id_ex_flush  = 1'b1;
      hz.ex_mem_flush = 1'b1;
    end else if (stall) begin
      hz.pc_write     = 1'b0;
      hz.if_id_write  = 1'b0;
      hz.id_ex_bubble = 1'b1;
    end
  end

  // Event counters stick at all-ones instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (hz.branch_taken && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign hz.stall_events = stall_q;
  assign hz.flush_events = flush_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; covers whichever HAZARD_FORWARD_EN build it is compiled with.
module tb_hazard_ctrl;
  import pipe_pkg::*;

  localparam int CNT_W = 3;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .hz   (hz.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    hz.id_rs        = 5'd0;
    hz.id_rt        = 5'd0;
    hz.id_uses_rt   = 1'b0;
    hz.ex_MemRead   = 1'b0;
    hz.ex_RegWrite  = 1'b0;
    hz.ex_reg_dest  = 5'd0;
    hz.ex_rs        = 5'd0;
    hz.ex_rt        = 5'd0;
    hz.mem_RegWrite = 1'b0;
    hz.mem_reg_dest = 5'd0;
    hz.wb_RegWrite  = 1'b0;
    hz.wb_reg_dest  = 5'd0;
    hz.branch_taken = 1'b0;
  endtask

  // Producer $3 in EX read through rt by the ID instruction (a load when forwarding).
  task automatic set_hazard();
    hz.ex_RegWrite = 1'b1;
    hz.ex_reg_dest = 5'd3;
    hz.id_rs       = 5'd1;
    hz.id_rt       = 5'd3;
    hz.id_uses_rt  = 1'b1;
`ifdef HAZARD_FORWARD_EN
    hz.ex_MemRead  = 1'b1;
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    clear_inputs();
    #1 reset = 1'b1;
    #2;
    check("rst_pc_write",   32'(hz.pc_write),     32'd0);
    check("rst_if_id_write", 32'(hz.if_id_write), 32'd0);
    check("rst_bubble",     32'(hz.id_ex_bubble), 32'd1);
    check("rst_flush",      32'({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}), 32'd0);
    check("rst_fwd",        32'({hz.fwd_a, hz.fwd_b}), 32'd0);
    check("rst_stall_ev",   32'(hz.stall_events), 32'd0);
    check("rst_flush_ev",   32'(hz.flush_events), 32'd0);

    @(negedge clock);
    reset = 1'b0;
    tick();
    check("idle_pc_write", 32'(hz.pc_write),     32'd1);
    check("idle_bubble",   32'(hz.id_ex_bubble), 32'd0);
    check("idle_flush",    32'({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}), 32'd0);

    // Writes to $zero, rt not read, and non-writing producers are no hazard.
    hz.ex_RegWrite = 1'b1; hz.ex_MemRead = 1'b1; hz.ex_reg_dest = 5'd0;
    hz.id_rs = 5'd0; hz.id_uses_rt = 1'b1;
    #1 check("zero_dest_no_stall", 32'(hz.pc_write), 32'd1);
    hz.ex_reg_dest = 5'd3; hz.id_rs = 5'd1; hz.id_rt = 5'd3; hz.id_uses_rt = 1'b0;
    #1 check("rt_unused_no_stall", 32'(hz.pc_write), 32'd1);
    hz.id_uses_rt = 1'b1; hz.ex_RegWrite = 1'b0;
    #1 check("no_regwrite_no_stall", 32'(hz.pc_write), 32'd1);
    clear_inputs();

`ifdef HAZARD_FORWARD_EN
    // lw $2 followed by a reader of $2: exactly one bubble.
    hz.ex_MemRead = 1'b1; hz.ex_RegWrite = 1'b1; hz.ex_reg_dest = 5'd2; hz.id_rs = 5'd2;
    #1;
    check("lw_stall_pc",     32'(hz.pc_write),     32'd0);
    check("lw_stall_bubble", 32'(hz.id_ex_bubble), 32'd1);
    tick();
    clear_inputs();
    #1;
    check("lw_after_pc",  32'(hz.pc_write),     32'd1);
    check("lw_stall_ev",  32'(hz.stall_events), 32'd1);
    hz.ex_RegWrite = 1'b1; hz.ex_reg_dest = 5'd2; hz.id_rs = 5'd2;
    #1 check("alu_fwd_no_stall", 32'(hz.pc_write), 32'd1);
    clear_inputs();

    hz.mem_RegWrite = 1'b1; hz.mem_reg_dest = 5'd5;
    hz.wb_RegWrite  = 1'b1; hz.wb_reg_dest  = 5'd5;
    hz.ex_rs = 5'd5; hz.ex_rt = 5'd5;
    #1;
    check("fwd_a_mem_wins", 32'(hz.fwd_a), 32'(2'b10));
    check("fwd_b_mem_wins", 32'(hz.fwd_b), 32'(2'b10));
    hz.mem_RegWrite = 1'b0;
    #1 check("fwd_a_wb", 32'(hz.fwd_a), 32'(2'b01));
    hz.mem_RegWrite = 1'b1; hz.mem_reg_dest = 5'd0;
    hz.wb_RegWrite  = 1'b1; hz.wb_reg_dest  = 5'd0; hz.ex_rs = 5'd0;
    #1 check("fwd_a_zero_reg", 32'(hz.fwd_a), 32'(2'b00));
    clear_inputs();

    set_hazard();
    hz.branch_taken = 1'b1;
    #1;
    check("br_flushes", 32'({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}), 32'd7);
    check("br_pc_write", 32'(hz.pc_write),     32'd1);
    check("br_bubble",   32'(hz.id_ex_bubble), 32'd0);
    tick();
    check("br_flush_ev", 32'(hz.flush_events), 32'd1);
    check("br_stall_ev", 32'(hz.stall_events), 32'd1);
    clear_inputs();
    #1 check("br_after_pc", 32'(hz.pc_write), 32'd1);
`else
    // ALU producer in EX: two bubbles, then back to RUN.
    set_hazard();
    #1 check("ex_stall1_pc", 32'(hz.pc_write), 32'd0);
    tick();
    clear_inputs();
    hz.mem_RegWrite = 1'b1; hz.mem_reg_dest = 5'd3; hz.id_rt = 5'd3; hz.id_uses_rt = 1'b1;
    #1;
    check("ex_stall2_pc",     32'(hz.pc_write),     32'd0);
    check("ex_stall2_bubble", 32'(hz.id_ex_bubble), 32'd1);
    check("ex_stall2_ev",     32'(hz.stall_events), 32'd1);
    tick();
    clear_inputs();
    #1;
    check("ex_run_pc",   32'(hz.pc_write),     32'd1);
    check("ex_stall_ev", 32'(hz.stall_events), 32'd2);

    // MEM producer alone: one bubble.
    hz.mem_RegWrite = 1'b1; hz.mem_reg_dest = 5'd4; hz.id_rs = 5'd4;
    #1 check("mem_stall_pc", 32'(hz.pc_write), 32'd0);
    tick();
    clear_inputs();
    #1;
    check("mem_run_pc",   32'(hz.pc_write),     32'd1);
    check("mem_stall_ev", 32'(hz.stall_events), 32'd3);

    hz.mem_RegWrite = 1'b1; hz.mem_reg_dest = 5'd5; hz.ex_rs = 5'd5; hz.ex_rt = 5'd5;
    #1 check("fwd_tied_off", 32'({hz.fwd_a, hz.fwd_b}), 32'd0);
    clear_inputs();

    // Branch in the second stall cycle abandons the stall.
    set_hazard();
    #1 check("br_stall1_pc", 32'(hz.pc_write), 32'd0);
    tick();
    clear_inputs();
    hz.branch_taken = 1'b1;
    #1;
    check("br_flushes", 32'({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}), 32'd7);
    check("br_pc_write", 32'(hz.pc_write),     32'd1);
    check("br_bubble",   32'(hz.id_ex_bubble), 32'd0);
    tick();
    hz.branch_taken = 1'b0;
    #1;
    check("br_flush_ev", 32'(hz.flush_events), 32'd1);
    check("br_stall_ev", 32'(hz.stall_events), 32'd4);
    check("br_after_pc", 32'(hz.pc_write),     32'd1);
`endif

    // Continuous stalls drive the 3-bit counter into saturation.
    set_hazard();
    for (int i = 0; i < 8; i++) tick();
    check("sat_stall_ev", 32'(hz.stall_events), 32'd7);
    check("sat_stalling", 32'(hz.pc_write),     32'd0);
    tick();
    check("sat_hold",     32'(hz.stall_events), 32'd7);

    clear_inputs();
    tick();
    tick();
    set_hazard();
    #1 check("pre_rst_stall", 32'(hz.pc_write), 32'd0);
    tick();
`ifndef HAZARD_FORWARD_EN
    clear_inputs();
    #1 check("stall_state_pc", 32'(hz.pc_write), 32'd0);
`endif
    hz.branch_taken = 1'b1;
    reset = 1'b1;
    #1;
    check("midrst_pc_write", 32'(hz.pc_write),     32'd0);
    check("midrst_bubble",   32'(hz.id_ex_bubble), 32'd1);
    check("midrst_flush",    32'({hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush}), 32'd0);
    check("midrst_stall_ev", 32'(hz.stall_events), 32'd0);
    check("midrst_flush_ev", 32'(hz.flush_events), 32'd0);
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    #1 check("post_rst_pc", 32'(hz.pc_write), 32'd1);
    tick();
    check("post_rst_run",   32'(hz.pc_write),     32'd1);
    check("post_rst_ev",    32'(hz.stall_events), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: CNT_W, 16, width of the stall and flush event counters.
REQ-002 clock  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 id_rs, id_rt  in  5 each  source registers of the instruction in ID.
REQ-005 id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
REQ-006 ex_MemRead, ex_RegWrite  in  1 each  ID/EX control outputs of the instruction in EX.
REQ-007 ex_reg_dest  in  5  resolved destination (RegDst applied) of the instruction in EX.
REQ-008 ex_rs, ex_rt  in  5 each  source registers of the instruction in EX.
REQ-009 mem_RegWrite, mem_reg_dest  in  1, 5  EX/MEM writer.
REQ-010 wb_RegWrite, wb_reg_dest  in  1, 5  MEM/WB writer.
REQ-011 branch_taken  in  1  taken branch resolved in MEM.
REQ-012 pc_write, if_id_write  out  1 each  enable PC and IF/ID update.
REQ-013 id_ex_bubble  out  1  force all ID/EX control inputs to 0.
REQ-014 if_id_flush, id_ex_flush, ex_mem_flush  out  1 each  squash those registers.
REQ-015 fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
REQ-016 stall_events, flush_events  out  CNT_W each  saturating event counters.

Function
REQ-017 States: RUN, STALL; registered 2-bit remaining-stall counter cnt.
REQ-018 Hazard match: producer writes (RegWrite=1), dest != 0, and dest == id_rs or (id_uses_rt and dest == id_rt).
REQ-019 Required stalls n (forwarding on): ex_MemRead and EX match -> 1, else 0.
REQ-020 Required stalls n (forwarding off): EX match -> 2; else MEM match -> 1; else 0; register file is write-before-read, so WB never stalls.
REQ-021 Stall cycle: pc_write=0, if_id_write=0, id_ex_bubble=1; otherwise pc_write=1, if_id_write=1, id_ex_bubble=0.
REQ-022 RUN with n>=1: current cycle is a stall cycle; n=2 -> STALL with cnt=1; n=1 -> remain RUN.
REQ-023 STALL: stall cycle regardless of hazard inputs; cnt decrements; at cnt=0 after the cycle -> RUN, hazards re-evaluated.
REQ-024 branch_taken=1: same cycle if_id_flush=id_ex_flush=ex_mem_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0; overrides any stall; next state RUN, cnt=0.
REQ-025 stall_events += 1 on every stall cycle; flush_events += 1 per branch_taken cycle; both saturate at all-ones, never wrap.
REQ-026 Forwarding (combinational): fwd_a=10 if mem_RegWrite, mem_reg_dest!=0, mem_reg_dest==ex_rs; else 01 if same on wb; else 00; fwd_b likewise on ex_rt; MEM beats WB.

Reset
REQ-027 Reset asserted: state=RUN, cnt=0, counters=0 immediately, independent of clock.
REQ-028 While reset high: pc_write=0, if_id_write=0, id_ex_bubble=1, all flushes 0, fwd_a=fwd_b=00.
REQ-029 Reset mid-STALL aborts the stall; first cycle after release evaluates fresh in RUN.

Configuration
REQ-030 Macro HAZARD_FORWARD_EN defined: REQ-019 stall rule and REQ-026 forwarding active.
REQ-031 HAZARD_FORWARD_EN undefined: REQ-020 stall rule; fwd_a, fwd_b ports remain and are tied 00.

Structure
REQ-032 Shared package pipe_pkg holds: state enum (RUN, STALL), fwd select constants (FWD_RF, FWD_MEM, FWD_WB), REG_ZERO.
REQ-033 Forwarding logic is one combinational sub-module hazard_fwd_unit, instantiated twice (operands a, b).

Verification
REQ-034 FWD on: lw $2 in EX (ex_MemRead=1, ex_RegWrite=1, dest 2), add with id_rs=2 -> one cycle pc_write=0, id_ex_bubble=1; next cycle clear; stall_events=1.
REQ-035 FWD off: add $3 in EX, ID reads rt=3 with id_uses_rt=1 -> two consecutive stall cycles, then RUN; stall_events=2.
REQ-036 FWD off: 2-cycle stall started, branch_taken=1 in second cycle -> three flushes high, pc_write=1, STALL abandoned, flush_events=1.
REQ-037 FWD on: mem dest 5 and wb dest 5, ex_rs=5 -> fwd_a=10; mem dest 0 matching ex_rs=0 -> fwd_a=00.
REQ-038 Preload stall_events to all-ones, force stall -> value unchanged; assert reset mid-STALL -> outputs per REQ-028 without clock edge, counters 0.
